// File: rtl/cpu10_pkg.sv
// Shared definitions for the 10-bit pipelined CPU: opcodes, HALT function code,
// jump-field sign extension and the fetch FSM encoding.
package cpu10_pkg;

  localparam int unsigned PC_W = 10;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_SHIFT = 3'b001;
  localparam logic [2:0] OP_BNE   = 3'b010;
  localparam logic [2:0] OP_ADDI  = 3'b011;
  localparam logic [2:0] OP_JMP   = 3'b100;
  localparam logic [2:0] OP_BEQ   = 3'b101;
  localparam logic [2:0] OP_LOAD  = 3'b110;
  localparam logic [2:0] OP_STORE = 3'b111;

  localparam logic [1:0] FUNC_HALT = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  function automatic logic [PC_W-1:0] sext_jmp(input logic [6:0] field);
    return {{3{field[6]}}, field};
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Bundle of the fetch stage's ROM, hazard/EX control and IF/ID outputs.
// master = fetch stage, slave = surrounding pipeline / ROM.
interface if_id_stage_if #(
  parameter int unsigned CNT_W = 16
);
  logic [9:0]       imem_addr;
  logic [9:0]       imem_rdata;
  logic             stall;
  logic             redirect;
  logic [9:0]       redirect_pc;
  logic             halt_commit;
  logic             id_valid;
  logic [9:0]       id_instr;
  logic [9:0]       id_pc;
  logic [9:0]       id_pc_plus1;
  logic             fetch_halted;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    output imem_addr, id_valid, id_instr, id_pc, id_pc_plus1, fetch_halted, fetch_count,
    input  imem_rdata, stall, redirect, redirect_pc, halt_commit
  );

  modport slave (
    input  imem_addr, id_valid, id_instr, id_pc, id_pc_plus1, fetch_halted, fetch_count,
    output imem_rdata, stall, redirect, redirect_pc, halt_commit
  );
endinterface

// File: rtl/fetch_predecode.sv
// Combinational JMP/HALT detector; shared with the decode stage.
module fetch_predecode
  import cpu10_pkg::*;
(
  input  logic [9:0] instr_i,
  output logic       is_jmp_o,
  output logic       is_halt_o,
  output logic [9:0] jmp_target_o
);
  assign is_jmp_o     = (instr_i[9:7] == OP_JMP);
  assign is_halt_o    = (instr_i[9:7] == OP_SHIFT) && (instr_i[1:0] == FUNC_HALT);
  assign jmp_target_o = sext_jmp(instr_i[6:0]);
endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch + IF/ID register: owns the PC, resolves JMP early,
// parks in HOLD after a fetched HALT and in HALTED once EX commits it.
module if_id_stage
  import cpu10_pkg::*;
#(
  parameter logic [9:0]  RESET_PC = 10'd0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  if_id_stage_if.master  bus
);
  fetch_state_e     state_q;
  logic [9:0]       pc_q;
  logic             id_valid_q;
  logic [9:0]       id_instr_q;
  logic [9:0]       id_pc_q;
  logic [9:0]       id_pc_plus1_q;
  logic             halted_q;
  logic [CNT_W-1:0] cnt_q;
  logic [9:0]       pc_d;

  logic       is_jmp;
  logic       is_halt;
  logic [9:0] jmp_target;

  fetch_predecode u_predecode (
    .instr_i      (bus.imem_rdata),
    .is_jmp_o     (is_jmp),
    .is_halt_o    (is_halt),
    .jmp_target_o (jmp_target)
  );

  // Next PC for a normal RUN advance; a fetched HALT parks the PC on itself.
  always_comb begin
    pc_d = pc_q + 10'd1;
    if (is_jmp)       pc_d = jmp_target;
    else if (is_halt) pc_d = pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_instr_q    <= '0;
      id_pc_q       <= '0;
      id_pc_plus1_q <= 10'd1;
      halted_q      <= 1'b0;
      cnt_q         <= '0;
    end else if (state_q != ST_HALTED) begin
      if (bus.halt_commit) begin
        state_q    <= ST_HALTED;
        halted_q   <= 1'b1;
        id_valid_q <= 1'b0;
      end else if (bus.redirect) begin
        state_q    <= ST_RUN;
        pc_q       <= bus.redirect_pc;
        id_valid_q <= 1'b0;
      end else if (!bus.stall) begin
        if (state_q == ST_RUN) begin
          id_valid_q    <= 1'b1;
          id_instr_q    <= bus.imem_rdata;
          id_pc_q       <= pc_q;
          id_pc_plus1_q <= pc_q + 10'd1;
          pc_q          <= pc_d;
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          if (is_halt) state_q <= ST_HOLD;
        end else begin
          id_valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.id_valid     = id_valid_q;
  assign bus.id_instr     = id_instr_q;
  assign bus.id_pc        = id_pc_q;
  assign bus.id_pc_plus1  = id_pc_plus1_q;
  assign bus.fetch_halted = halted_q;
  assign bus.fetch_count  = cnt_q;
endmodule
